// File: rtl/multi_clock_divider_pkg.sv
// Shared types and constants for the multi-channel clock divider.
// Optional phase sync is enabled by defining MULTI_CLOCK_DIVIDER_PHASE_SYNC_EN.
package multi_clock_divider_pkg;

    localparam int          DIV_W_DEF       = 27;
    localparam int unsigned DEFAULT_DIV_VAL = 100_000_000;

    // Config fields are held at a fixed container width so one struct serves any DIV_W <= 31.
    localparam int CFG_W = 32;

    typedef struct packed {
        logic [CFG_W-1:0] div;
        logic [CFG_W-1:0] high;
    } ch_cfg_t;

    typedef enum logic [1:0] {
        ST_STOP,
        ST_IDLE,
        ST_RUN
    } ch_state_t;

endpackage

// File: rtl/div_channel.sv
// One divider channel: period counter, active/shadow config, pending flag, registered outputs.
// With MULTI_CLOCK_DIVIDER_PHASE_SYNC_EN defined, sync_in restarts a running period.
module div_channel
    import multi_clock_divider_pkg::*;
#(
    parameter int          DIV_W       = DIV_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_VAL
) (
    input  logic             clk,
    input  logic             reset,
`ifdef MULTI_CLOCK_DIVIDER_PHASE_SYNC_EN
    input  logic             sync_in,
`endif
    input  logic             en,
    input  logic             wr_hit,
    input  logic [DIV_W-1:0] wr_div,
    input  logic [DIV_W-1:0] wr_high,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    localparam ch_cfg_t   RST_CFG   = '{div: CFG_W'(DEFAULT_DIV), high: CFG_W'(DEFAULT_DIV / 2)};
    localparam ch_state_t RST_STATE = (DEFAULT_DIV == 0) ? ST_STOP : ST_IDLE;

    ch_state_t        state, state_next;
    logic [DIV_W-1:0] cnt, cnt_next;
    ch_cfg_t          active, shadow, shadow_next, eff;
    logic             run, wrap, restart, apply;
    logic             clk_next, tick_next, pending_next;

    always_comb begin
        run          = (state == ST_RUN);
        wrap         = run && ((CFG_W'(cnt) + CFG_W'(1)) >= active.div);
        restart      = wrap;
`ifdef MULTI_CLOCK_DIVIDER_PHASE_SYNC_EN
        restart      = wrap || (run && sync_in);
`endif
        // A pending shadow lands only at a period boundary, or at once when not running.
        apply        = pending && (!run || restart);
        eff          = apply ? shadow : active;

        state_next   = ST_RUN;
        if (eff.div == '0)
            state_next = ST_STOP;
        else if (!en)
            state_next = ST_IDLE;

        cnt_next = '0;
        if (state_next == ST_RUN && run && !restart)
            cnt_next = cnt + DIV_W'(1);

        // Outputs are registered against the counter value they will accompany.
        clk_next     = (state_next == ST_RUN) && (CFG_W'(cnt_next) < eff.high);
        tick_next    = (state_next == ST_RUN) && (cnt_next == '0);

        shadow_next  = shadow;
        if (wr_hit)
            shadow_next = '{div: CFG_W'(wr_div), high: CFG_W'(wr_high)};
        pending_next = wr_hit || (pending && !apply);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RST_STATE;
            cnt     <= '0;
            active  <= RST_CFG;
            shadow  <= RST_CFG;
            pending <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            active  <= eff;
            shadow  <= shadow_next;
            pending <= pending_next;
            clk_out <= clk_next;
            tick    <= tick_next;
        end
    end

endmodule

// File: rtl/multi_clock_divider.sv
// NUM_CH independent programmable dividers sharing one config write port.
// Define MULTI_CLOCK_DIVIDER_PHASE_SYNC_EN to add the sync_in phase-alignment input.
module multi_clock_divider
    import multi_clock_divider_pkg::*;
#(
    parameter int          NUM_CH      = 4,
    parameter int          DIV_W       = DIV_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_VAL,
    parameter int          CH_W        = 2
) (
    input  logic              clk,
    input  logic              reset,
`ifdef MULTI_CLOCK_DIVIDER_PHASE_SYNC_EN
    input  logic              sync_in,
`endif
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [DIV_W-1:0]  wr_div,
    input  logic [DIV_W-1:0]  wr_high,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Out-of-range channel numbers match no instance and so are dropped.
        logic wr_hit;
        assign wr_hit = wr_en && (wr_ch == CH_W'(i));

        div_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
`ifdef MULTI_CLOCK_DIVIDER_PHASE_SYNC_EN
            .sync_in (sync_in),
`endif
            .en      (ch_en[i]),
            .wr_hit  (wr_hit),
            .wr_div  (wr_div),
            .wr_high (wr_high),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .pending (pending[i])
        );
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Self-checking bench for multi_clock_divider against a period/phase reference model.
// Covers MULTI_CLOCK_DIVIDER_PHASE_SYNC_EN when that macro is defined.
module tb_multi_clock_divider;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 27;
    localparam int CH_W   = 3;
    localparam int DEF    = 10;

    logic              clk = 1'b0, reset = 1'b1, wr_en = 1'b0, sync_in = 1'b0;
    logic [NUM_CH-1:0] ch_en = '0;
    logic [CH_W-1:0]   wr_ch = '0;
    logic [DIV_W-1:0]  wr_div = '0, wr_high = '0;
    logic [NUM_CH-1:0] clk_out, tick, pending;
    int                n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    multi_clock_divider #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(DEF), .CH_W(CH_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
`ifdef MULTI_CLOCK_DIVIDER_PHASE_SYNC_EN
        .sync_in (sync_in),
`endif
        .ch_en   (ch_en),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
        .wr_high (wr_high),
        .clk_out (clk_out),
        .tick    (tick),
        .pending (pending)
    );

    // Reference: each channel is a position within its current period (-1 = not running).
    int                m_div[NUM_CH], m_high[NUM_CH], m_sdiv[NUM_CH], m_shigh[NUM_CH], m_pos[NUM_CH];
    bit                m_pnd[NUM_CH];
    logic [NUM_CH-1:0] m_clk = '0, m_tick = '0, m_pend = '0;
    bit                run, bnd;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_div[i] = DEF; m_high[i] = DEF / 2; m_sdiv[i] = DEF; m_shigh[i] = DEF / 2;
                m_pnd[i] = 1'b0; m_pos[i] = -1;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                run = (m_pos[i] >= 0);
                bnd = !run || (m_pos[i] + 1 == m_div[i]) || (sync_in === 1'b1);
                if (m_pnd[i] && bnd) begin
                    m_div[i] = m_sdiv[i]; m_high[i] = m_shigh[i]; m_pnd[i] = 1'b0;
                end
                if (wr_en && int'(wr_ch) == i) begin
                    m_sdiv[i] = int'(wr_div); m_shigh[i] = int'(wr_high); m_pnd[i] = 1'b1;
                end
                if (m_div[i] == 0 || !ch_en[i]) m_pos[i] = -1;
                else m_pos[i] = bnd ? 0 : m_pos[i] + 1;
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            m_clk[i]  = (m_pos[i] >= 0) && (m_pos[i] < m_high[i]);
            m_tick[i] = (m_pos[i] == 0);
            m_pend[i] = m_pnd[i];
        end
    end

    task automatic do_write(input int ch, input int d, input int h);
        wr_en = 1'b1; wr_ch = CH_W'(ch); wr_div = DIV_W'(d); wr_high = DIV_W'(h);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ch_en = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (clk_out !== '0 || tick !== '0 || pending !== '0) begin
            n_bad++;
            $display("FAIL reset clk_out=%b tick=%b pending=%b want 0000/0000/0000", clk_out, tick, pending);
        end
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({clk_out, tick, pending} !== {m_clk, m_tick, m_pend}) begin
                n_bad++;
                $display("FAIL idle_after_reset c=%0d got %b/%b/%b want %b/%b/%b", c, clk_out, tick, pending, m_clk, m_tick, m_pend);
            end
        end
    endtask

    task automatic test_default();
        int ticks = 0, highs = 0, aligned = 0;
        ch_en = '1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({clk_out, tick, pending} !== {m_clk, m_tick, m_pend}) begin
                n_bad++;
                $display("FAIL default c=%0d got %b/%b/%b want %b/%b/%b", c, clk_out, tick, pending, m_clk, m_tick, m_pend);
            end
            ticks += int'(tick[0]); highs += int'(clk_out[0]);
            if (tick[0] && clk_out[0] && (c % 10 == 0)) aligned++;
        end
        n_cmp++;
        if (ticks != 3 || highs != 15 || aligned != 3) begin
            n_bad++;
            $display("FAIL default_shape ticks=%0d highs=%0d aligned=%0d want 3/15/3", ticks, highs, aligned);
        end
    endtask

    task automatic test_mid_write();
        repeat (3) @(negedge clk);
        do_write(1, 7, 2);
        n_cmp++;
        if (pending[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_write_pending got %b want 1", pending[1]);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({clk_out, tick, pending} !== {m_clk, m_tick, m_pend}) begin
                n_bad++;
                $display("FAIL mid_write c=%0d got %b/%b/%b want %b/%b/%b", c, clk_out, tick, pending, m_clk, m_tick, m_pend);
            end
        end
    endtask

    task automatic test_stop();
        do_write(2, 0, 0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({clk_out, tick, pending} !== {m_clk, m_tick, m_pend}) begin
                n_bad++;
                $display("FAIL stop c=%0d got %b/%b/%b want %b/%b/%b", c, clk_out, tick, pending, m_clk, m_tick, m_pend);
            end
        end
        n_cmp++;
        if (clk_out[2] !== 1'b0 || tick[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL stop_held clk_out=%b tick=%b want 0/0", clk_out[2], tick[2]);
        end
        do_write(2, 1, 1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({clk_out, tick, pending} !== {m_clk, m_tick, m_pend}) begin
                n_bad++;
                $display("FAIL div1 c=%0d got %b/%b/%b want %b/%b/%b", c, clk_out, tick, pending, m_clk, m_tick, m_pend);
            end
            if (c >= 1) begin
                n_cmp++;
                if (clk_out[2] !== 1'b1 || tick[2] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL div1_const c=%0d clk_out=%b tick=%b want 1/1", c, clk_out[2], tick[2]);
                end
            end
        end
    endtask

    task automatic test_const_high();
        int ticks = 0;
        do_write(0, 10, 12);
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({clk_out, tick, pending} !== {m_clk, m_tick, m_pend}) begin
                n_bad++;
                $display("FAIL const_high c=%0d got %b/%b/%b want %b/%b/%b", c, clk_out, tick, pending, m_clk, m_tick, m_pend);
            end
            if (c >= 12) begin
                ticks += int'(tick[0]);
                n_cmp++;
                if (clk_out[0] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL const_high_level c=%0d clk_out=%b want 1", c, clk_out[0]);
                end
            end
        end
        n_cmp++;
        if (ticks < 1 || ticks > 2) begin
            n_bad++;
            $display("FAIL const_high_ticks got %0d want 1..2", ticks);
        end
        do_write(5, 3, 1);
        n_cmp++;
        if (pending !== '0) begin
            n_bad++;
            $display("FAIL bad_ch_pending got %b want 0000", pending);
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({clk_out, tick, pending} !== {m_clk, m_tick, m_pend}) begin
                n_bad++;
                $display("FAIL bad_ch c=%0d got %b/%b/%b want %b/%b/%b", c, clk_out, tick, pending, m_clk, m_tick, m_pend);
            end
        end
    endtask

    task automatic test_enable();
        repeat (4) @(negedge clk);
        ch_en[3] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (clk_out[3] !== 1'b0 || tick[3] !== 1'b0 || {clk_out, tick} !== {m_clk, m_tick}) begin
                n_bad++;
                $display("FAIL disable c=%0d clk_out=%b tick=%b want %b/%b", c, clk_out, tick, m_clk, m_tick);
            end
        end
        ch_en[3] = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (tick[3] !== 1'b1 || clk_out[3] !== 1'b1) begin
            n_bad++;
            $display("FAIL reenable clk_out=%b tick=%b want 1/1", clk_out[3], tick[3]);
        end
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({clk_out, tick, pending} !== {m_clk, m_tick, m_pend}) begin
                n_bad++;
                $display("FAIL reenable_run c=%0d got %b/%b/%b want %b/%b/%b", c, clk_out, tick, pending, m_clk, m_tick, m_pend);
            end
        end
    endtask

`ifdef MULTI_CLOCK_DIVIDER_PHASE_SYNC_EN
    task automatic test_sync();
        do_write(0, 10, 5);
        do_write(1, 4, 2);
        repeat (15) @(negedge clk);
        sync_in = 1'b1;
        @(negedge clk);
        sync_in = 1'b0;
        n_cmp++;
        if (tick[1:0] !== 2'b11 || {clk_out, tick, pending} !== {m_clk, m_tick, m_pend}) begin
            n_bad++;
            $display("FAIL sync_tick got tick=%b want %b (ch0/1 = 11)", tick, m_tick);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({clk_out, tick, pending} !== {m_clk, m_tick, m_pend}) begin
                n_bad++;
                $display("FAIL sync_run c=%0d got %b/%b/%b want %b/%b/%b", c, clk_out, tick, pending, m_clk, m_tick, m_pend);
            end
        end
        n_cmp++;
        if (tick[1:0] !== 2'b11) begin
            n_bad++;
            $display("FAIL sync_align got tick=%b want xx11", tick);
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({clk_out, tick, pending} !== {m_clk, m_tick, m_pend}) begin
                n_bad++;
                $display("FAIL random c=%0d got %b/%b/%b want %b/%b/%b", c, clk_out, tick, pending, m_clk, m_tick, m_pend);
            end
            reset   = ($urandom_range(0, 299) == 0);
            wr_en   = ($urandom_range(0, 7) == 0);
            wr_ch   = CH_W'($urandom_range(0, 7));
            wr_div  = DIV_W'($urandom_range(0, 12));
            wr_high = DIV_W'($urandom_range(0, 14));
            if ($urandom_range(0, 19) == 0) ch_en[$urandom_range(0, NUM_CH - 1)] ^= 1'b1;
`ifdef MULTI_CLOCK_DIVIDER_PHASE_SYNC_EN
            sync_in = ($urandom_range(0, 24) == 0);
`endif
        end
        reset = 1'b0; wr_en = 1'b0; sync_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default();
        test_mid_write();
        test_stop();
        test_const_high();
        test_enable();
`ifdef MULTI_CLOCK_DIVIDER_PHASE_SYNC_EN
        test_sync();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_clock_divider.md
Name: multi_clock_divider

Overview:
- Parametrised successor to the fixed single-output divider.
- Generates NUM_CH independent divided clocks from one system clock.
- Each channel has a runtime-programmable period and high time (duty), per-channel enable and a period-start tick.
- Sits beside the system clock source. Feeds slow-logic enables, LED/display scan and baud-style timing. Outputs are used as enables, not routed as clock trees.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- DIV_W, 27, width of period and high-time values; covers 100_000_000.
- DEFAULT_DIV, 100_000_000, reset period in clk cycles (1 Hz from 100 MHz).
- CH_W, 2, width of channel select; must satisfy 2**CH_W >= NUM_CH.

Ports:
- clk  in  1  system clock (100 MHz nominal).
- reset  in  1  asynchronous, active-high reset.
- ch_en  in  NUM_CH  per-channel run enable.
- wr_en  in  1  one-cycle write strobe for configuration.
- wr_ch  in  CH_W  channel addressed by the write.
- wr_div  in  DIV_W  new period in cycles; 0 = channel stopped.
- wr_high  in  DIV_W  new high time in cycles.
- clk_out  out  NUM_CH  divided clock per channel, registered.
- tick  out  NUM_CH  one-cycle pulse at each period start, registered.
- pending  out  NUM_CH  shadow config written but not yet applied.

Behaviour:
- Reset (async, active-high) sets, for every channel:
  - cnt=0, clk_out=0, tick=0, pending=0;
  - active div=DEFAULT_DIV, active high=DEFAULT_DIV/2;
  - shadow registers = active values.
- Counter: cnt runs 0..div-1, then wraps to 0. Period is exactly div cycles.
- Output rules:
  - clk_out is registered, equal to (cnt < high) for the current cnt.
  - tick=1 in the cycle cnt==0 (first cycle of each period), aligned with the clk_out rising edge.
- Width: comparisons are unsigned DIV_W. high>=div gives constant 1. high==0 gives constant 0, but tick still pulses.
- div==1: cnt stays 0, tick=1 every cycle, clk_out=(high>=1).
- div==0: channel stopped. cnt held 0, clk_out=0, tick=0.
- Config write: when wr_en=1 and wr_ch<NUM_CH:
  - shadow{div,high} <= {wr_div,wr_high};
  - pending[ch] <= 1.
  - wr_ch>=NUM_CH is ignored; no state changes.
- Apply: a pending shadow loads into the active registers on the cycle cnt wraps to 0. pending clears in that same cycle. The period in progress always completes at the old setting, so output is glitch-free.
- Stopped or disabled channel: pending shadow applies on the next clk edge. pending is high for exactly one cycle.
- Back-to-back writes to one channel before apply: last write wins, and only one apply occurs.
- Write in the same cycle as wrap: the old shadow applies now. The new write lands in the shadow with pending=1 and applies at the next wrap.
- Per-channel states:
  - STOP (div==0);
  - IDLE (ch_en=0): cnt=0, clk_out=0, tick=0;
  - RUN.
  - IDLE to RUN: first cycle after ch_en rises has cnt=0, tick=1, clk_out=(high>0).
  - RUN to IDLE: outputs drop to 0 on the next edge. No partial-period completion.
- Reset mid-period: immediate return to the reset state. Pending writes are lost.
- Channels are fully independent; no cross-channel ordering.

Optional Feature:
- Macro: MULTI_CLOCK_DIVIDER_PHASE_SYNC_EN.
- With the macro defined:
  - adds input port sync_in (1 bit).
  - A cycle with sync_in=1 forces every RUN channel to cnt=0 on the next edge, with tick=1.
  - Pending shadows apply at that point. All channels become phase-aligned.
  - sync_in has priority over a natural wrap in the same cycle.
  - sync_in is ignored for STOP/IDLE channels.
- Without the macro: the port is absent and no sync logic is built.

Decomposition:
- Package multi_clock_divider_pkg holds:
  - the DIV_W default;
  - the channel config struct {div, high};
  - state enum STOP/IDLE/RUN;
  - the DEFAULT_DIV constant.
- Sub-module div_channel implements one channel: counter, active and shadow registers, pending flag, output registers. The top level generate-loops NUM_CH instances and decodes wr_en/wr_ch.

Test Plan:
- Reset, DEFAULT_DIV overridden to 10, ch_en=all 1 -> clk_out[0] is 5 cycles high, 5 low. tick[0] pulses every 10 cycles, aligned with the rise.
- Write ch1 div=7 high=2 mid-period -> pending[1]=1 until the current period ends. Then 2 high/5 low. No runt pulse.
- Write ch2 div=0 -> clk_out[2]=0 and tick[2]=0 held. Then write div=1 high=1 -> clk_out[2]=1 constant, tick[2] every cycle.
- Write ch0 high=12 with div=10 -> clk_out[0] constant 1, tick[0] still every 10 cycles. Write wr_ch=5 with NUM_CH=4 -> no pending change on any channel.
- Deassert ch_en[3] mid-period, reassert after 3 cycles -> outputs 0 the next edge. On re-enable: cnt=0, tick=1 in the first cycle.
- With MULTI_CLOCK_DIVIDER_PHASE_SYNC_EN, channels at div=10 and div=4 -> one-cycle sync_in produces tick=1 on both channels next cycle. Then 20-cycle common alignment.
